// File: rtl/if_pkg.sv
// Shared types and helpers for the IF-stage fetch-PC generator.
// Optional macro IF_PC_BHT_EN adds a 2-bit saturating counter to each BTB entry.
package if_pkg;

  // Fixed instruction size; the low address bits below it are always zero.
  localparam int INSTR_BYTES = 4;
  localparam int OFS_W       = $clog2(INSTR_BYTES);

  // Upper bound on XLEN; BTB entry fields are sized to it and the unused
  // upper bits stay constant zero.
  localparam int MAX_XLEN = 64;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
`ifdef IF_PC_BHT_EN
    logic [1:0]          ctr;
`endif
  } btb_entry_t;

  // BTB index: the idx_w address bits just above the instruction offset.
  function automatic logic [MAX_XLEN-1:0] btb_idx(input logic [MAX_XLEN-1:0] pc,
                                                  input int                  idx_w);
    logic [MAX_XLEN-1:0] mask;
    mask = (MAX_XLEN'(1) << idx_w) - MAX_XLEN'(1);
    return (pc >> OFS_W) & mask;
  endfunction

  // BTB tag: every address bit above the index field.
  function automatic logic [MAX_XLEN-1:0] btb_tag(input logic [MAX_XLEN-1:0] pc,
                                                  input int                  idx_w);
    return pc >> (idx_w + OFS_W);
  endfunction

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
// With IF_PC_BHT_EN each entry carries a 2-bit saturating direction counter.
module if_btb
  import if_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int IDX_W = $clog2(BTB_DEPTH);

  btb_entry_t          r_btb [BTB_DEPTH];

  logic [IDX_W-1:0]    w_lk_idx;
  logic [MAX_XLEN-1:0] w_lk_tag;
  logic [IDX_W-1:0]    w_up_idx;
  logic [MAX_XLEN-1:0] w_up_tag;
  logic [MAX_XLEN-1:0] w_up_target;
  logic                w_up_tag_match;
  btb_entry_t          w_up_next;

  assign w_lk_idx = IDX_W'(btb_idx(MAX_XLEN'(i_lookup_pc), IDX_W));
  assign w_lk_tag = btb_tag(MAX_XLEN'(i_lookup_pc), IDX_W);
  assign w_up_idx = IDX_W'(btb_idx(MAX_XLEN'(i_upd_pc), IDX_W));
  assign w_up_tag = btb_tag(MAX_XLEN'(i_upd_pc), IDX_W);

  // Targets are word aligned, so the offset bits are stored as zero.
  assign w_up_target = MAX_XLEN'(i_upd_target & ~XLEN'(INSTR_BYTES - 1));

  assign w_up_tag_match = (r_btb[w_up_idx].tag == w_up_tag);

  // Lookup reads the array as registered, so a same-cycle update is seen next cycle.
  always_comb begin
    o_hit    = 1'b0;
    o_target = '0;
    if (r_btb[w_lk_idx].valid && (r_btb[w_lk_idx].tag == w_lk_tag)) begin
`ifdef IF_PC_BHT_EN
      o_hit = r_btb[w_lk_idx].ctr[1];
`else
      o_hit = 1'b1;
`endif
    end
    if (o_hit) begin
      o_target = XLEN'(r_btb[w_lk_idx].target);
    end
  end

  // Build the replacement entry for the indexed slot from the resolved outcome.
  always_comb begin
    w_up_next = r_btb[w_up_idx];
`ifdef IF_PC_BHT_EN
    if (i_upd_taken) begin
      if (r_btb[w_up_idx].valid && w_up_tag_match) begin
        w_up_next.target = w_up_target;
        if (r_btb[w_up_idx].ctr != 2'b11) begin
          w_up_next.ctr = r_btb[w_up_idx].ctr + 2'b01;
        end
      end else begin
        w_up_next.valid  = 1'b1;
        w_up_next.tag    = w_up_tag;
        w_up_next.target = w_up_target;
        w_up_next.ctr    = 2'b10;
      end
    end else if (r_btb[w_up_idx].valid && w_up_tag_match) begin
      if (r_btb[w_up_idx].ctr != 2'b00) begin
        w_up_next.ctr = r_btb[w_up_idx].ctr - 2'b01;
      end
    end
`else
    if (i_upd_taken) begin
      w_up_next.valid  = 1'b1;
      w_up_next.tag    = w_up_tag;
      w_up_next.target = w_up_target;
    end else if (w_up_tag_match) begin
      w_up_next.valid = 1'b0;
    end
`endif
  end

  // Entry storage; reset drops every entry so all lookups miss.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_btb[i] <= '0;
`ifdef IF_PC_BHT_EN
        r_btb[i].ctr <= 2'b01;
`endif
      end
    end else if (i_upd_valid) begin
      r_btb[w_up_idx] <= w_up_next;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-PC generator for the IF stage: PC register, BOOT/RUN state machine and
// next-PC priority mux (redirect > stall > BTB hit > sequential).
// Optional macro IF_PC_BHT_EN enables per-entry direction counters in the BTB.
module if_pc_gen
  import if_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_DEPTH    = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken,
  output logic [XLEN-1:0] o_pc_if,
  output logic            o_pc_valid,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target
);

  pc_state_e       r_state;
  pc_state_e       w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_target;
  logic [XLEN-1:0] w_redirect_pc;

  if_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_lookup_pc  (r_pc),
    .o_hit        (w_hit),
    .o_target     (w_hit_target),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_target (i_upd_target),
    .i_upd_taken  (i_upd_taken)
  );

  assign w_redirect_pc = i_redirect_pc & ~XLEN'(INSTR_BYTES - 1);

  assign o_pc_if       = r_pc;
  assign o_pred_taken  = w_hit;
  assign o_pred_target = w_hit_target;

  // State register: BOOT for exactly one cycle after reset release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC register; sits at the reset vector through reset and BOOT.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Next state and next PC; BOOT ignores redirects so the reset vector is fetched first.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    o_pc_valid   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        o_pc_valid = 1'b1;
        if (i_redirect_valid) begin
          w_pc_next = w_redirect_pc;
        end else if (i_stall) begin
          w_pc_next = r_pc;
        end else if (w_hit) begin
          w_pc_next = w_hit_target;
        end else begin
          w_pc_next = r_pc + XLEN'(INSTR_BYTES);
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural fetch/BTB model.
module tb_if_pc_gen;

  localparam int          DEPTH = 16;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic [31:0] i_upd_target;
  logic        i_upd_taken;
  logic [31:0] o_pc_if;
  logic        o_pc_valid;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;

  always #5 clk = ~clk;

  if_pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .BTB_DEPTH    (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_stall          (i_stall),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_upd_valid      (i_upd_valid),
    .i_upd_pc         (i_upd_pc),
    .i_upd_target     (i_upd_target),
    .i_upd_taken      (i_upd_taken),
    .o_pc_if          (o_pc_if),
    .o_pc_valid       (o_pc_valid),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference state: fetch PC, run flag and a table keyed by word index.
  logic [31:0] mPc;
  bit          mRun;
  bit          mValid [DEPTH];
  logic [31:0] mTag   [DEPTH];
  logic [31:0] mTgt   [DEPTH];
  int          mCtr   [DEPTH];

  function automatic int mIdx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] mTagOf(input logic [31:0] pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit mPredicts(input logic [31:0] pc);
    int i;
    i = mIdx(pc);
    if (!mValid[i] || mTag[i] != mTagOf(pc)) return 1'b0;
`ifdef IF_PC_BHT_EN
    return mCtr[i] >= 2;
`else
    return 1'b1;
`endif
  endfunction

  task automatic modelReset();
    mPc  = RV;
    mRun = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = '0;
      mTgt[i]   = '0;
      mCtr[i]   = 1;
    end
  endtask

  task automatic modelEdge(input bit st, input bit rv, input logic [31:0] rpc,
                           input bit uv, input logic [31:0] upc,
                           input logic [31:0] utg, input bit ut);
    logic [31:0] nxt;
    logic [31:0] t;
    int          i;
    if (!mRun) begin
      mRun = 1'b1;
      nxt  = mPc;
    end else if (rv) begin
      nxt = rpc & 32'hFFFF_FFFC;
    end else if (st) begin
      nxt = mPc;
    end else if (mPredicts(mPc)) begin
      nxt = mTgt[mIdx(mPc)];
    end else begin
      nxt = mPc + 32'd4;
    end
    if (uv) begin
      i = mIdx(upc);
      t = mTagOf(upc);
`ifdef IF_PC_BHT_EN
      if (ut) begin
        if (mValid[i] && mTag[i] == t) begin
          mCtr[i] = (mCtr[i] == 3) ? 3 : mCtr[i] + 1;
          mTgt[i] = utg & 32'hFFFF_FFFC;
        end else begin
          mValid[i] = 1'b1;
          mTag[i]   = t;
          mTgt[i]   = utg & 32'hFFFF_FFFC;
          mCtr[i]   = 2;
        end
      end else if (mValid[i] && mTag[i] == t && mCtr[i] > 0) begin
        mCtr[i] = mCtr[i] - 1;
      end
`else
      if (ut) begin
        mValid[i] = 1'b1;
        mTag[i]   = t;
        mTgt[i]   = utg & 32'hFFFF_FFFC;
      end else if (mValid[i] && mTag[i] == t) begin
        mValid[i] = 1'b0;
      end
`endif
    end
    mPc = nxt;
  endtask

  task automatic checkOutput(input string tagName, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tagName, obs, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic [31:0] expTgt;
    expTgt = mPredicts(mPc) ? mTgt[mIdx(mPc)] : 32'h0;
    checkOutput("pc", o_pc_if, mPc);
    checkOutput("pc_valid", 32'(o_pc_valid), 32'(mRun));
    checkOutput("pred_taken", 32'(o_pred_taken), 32'(mPredicts(mPc)));
    checkOutput("pred_target", o_pred_target, expTgt);
  endtask

  // One cycle: drive at the falling edge, check, clock, advance the model.
  task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc,
                               input bit uv, input logic [31:0] upc,
                               input logic [31:0] utg, input bit ut);
    i_stall          = st;
    i_redirect_valid = rv;
    i_redirect_pc    = rpc;
    i_upd_valid      = uv;
    i_upd_pc         = upc;
    i_upd_target     = utg;
    i_upd_taken      = ut;
    #1;
    checkModel();
    @(posedge clk);
    modelEdge(st, rv, rpc, uv, upc, utg, ut);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic redirectTo(input logic [31:0] pc);
    applyStimulus(1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic updateBtb(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, taken);
  endtask

  initial begin
    bit          st, rv, uv, ut;
    logic [31:0] rpc, upc, utg;

    rst_n = 1'b0;
    i_stall = 0; i_redirect_valid = 0; i_redirect_pc = 0;
    i_upd_valid = 0; i_upd_pc = 0; i_upd_target = 0; i_upd_taken = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_pc", o_pc_if, RV);
    checkOutput("reset_valid", 32'(o_pc_valid), 32'h0);
    checkOutput("reset_pred", 32'(o_pred_taken), 32'h0);
    rst_n = 1'b1;

    // Boot cycle then sequential fetch from the reset vector.
    #1;
    checkOutput("boot_valid", 32'(o_pc_valid), 32'h0);
    checkOutput("boot_pc", o_pc_if, RV);
    idle(1);
    checkOutput("run0_pc", o_pc_if, 32'h100);
    checkOutput("run0_valid", 32'(o_pc_valid), 32'h1);
    idle(1);
    checkOutput("run1_pc", o_pc_if, 32'h104);
    idle(1);
    checkOutput("run2_pc", o_pc_if, 32'h108);

    // Redirect overrides stall.
    redirectTo(32'h20);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("stall_hold", o_pc_if, 32'h20);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("stall_redir", o_pc_if, 32'h80);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);
    checkOutput("stall_release", o_pc_if, 32'h84);

    // Taken entry predicts, not-taken update stops the prediction.
    updateBtb(32'h40, 32'h200, 1'b1);
    redirectTo(32'h40);
    checkOutput("btb_hit", 32'(o_pred_taken), 32'h1);
    checkOutput("btb_target", o_pred_target, 32'h200);
    idle(1);
    checkOutput("btb_follow", o_pc_if, 32'h200);
    updateBtb(32'h40, 32'h200, 1'b0);
    redirectTo(32'h40);
    checkOutput("btb_nt_pred", 32'(o_pred_taken), 32'h0);
    checkOutput("btb_nt_tgt", o_pred_target, 32'h0);
    idle(1);
    checkOutput("btb_nt_next", o_pc_if, 32'h44);

`ifdef IF_PC_BHT_EN
    // Counter hysteresis: 01 -> 10 -> 01 -> 10 -> 11 -> 10.
    updateBtb(32'h40, 32'h200, 1'b1);
    redirectTo(32'h40);
    checkOutput("ctr_10", 32'(o_pred_taken), 32'h1);
    updateBtb(32'h40, 32'h200, 1'b0);
    redirectTo(32'h40);
    checkOutput("ctr_01", 32'(o_pred_taken), 32'h0);
    updateBtb(32'h40, 32'h200, 1'b1);
    updateBtb(32'h40, 32'h200, 1'b1);
    redirectTo(32'h40);
    checkOutput("ctr_11", 32'(o_pred_taken), 32'h1);
    updateBtb(32'h40, 32'h200, 1'b0);
    redirectTo(32'h40);
    checkOutput("ctr_sat_hold", 32'(o_pred_taken), 32'h1);
`endif

    // Aliasing: 0x440 shares an index with 0x40 and evicts it.
    updateBtb(32'h40, 32'h200, 1'b1);
    updateBtb(32'h440, 32'h300, 1'b1);
    redirectTo(32'h40);
    checkOutput("alias_miss", 32'(o_pred_taken), 32'h0);
    idle(1);
    checkOutput("alias_seq", o_pc_if, 32'h44);
    redirectTo(32'h440);
    checkOutput("alias_hit", 32'(o_pred_taken), 32'h1);
    checkOutput("alias_tgt", o_pred_target, 32'h300);
    idle(1);
    checkOutput("alias_follow", o_pc_if, 32'h300);

    // Address wrap at the top of the space.
    redirectTo(32'hFFFF_FFF8);
    idle(1);
    checkOutput("wrap_top", o_pc_if, 32'hFFFF_FFFC);
    idle(1);
    checkOutput("wrap_zero", o_pc_if, 32'h0);

    // Randomized traffic in a small address window so entries get reused.
    for (int c = 0; c < 600; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 127) * 4) | $urandom_range(0, 3);
      if ($urandom_range(0, 31) == 0) rpc = 32'hFFFF_FFF0;
      uv  = ($urandom_range(0, 2) == 0);
      upc = $urandom_range(0, 127) * 4;
      utg = $urandom_range(0, 511);
      ut  = ($urandom_range(0, 1) == 1);
      applyStimulus(st, rv, rpc, uv, upc, utg, ut);
    end

    // Asynchronous reset mid-cycle with an update pending.
    i_upd_valid = 1'b1; i_upd_pc = 32'h40; i_upd_target = 32'h123; i_upd_taken = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pc", o_pc_if, RV);
    checkOutput("midreset_valid", 32'(o_pc_valid), 32'h0);
    checkOutput("midreset_pred", 32'(o_pred_taken), 32'h0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    i_upd_valid = 1'b0;
    rst_n = 1'b1;

    // Redirect during BOOT is ignored.
    redirectTo(32'h80);
    checkOutput("boot_redir_ignored", o_pc_if, RV);

    // Every previously used address now misses.
    for (int a = 0; a < 128; a++) begin
      redirectTo(a * 4);
      checkOutput("post_reset_miss", 32'(o_pred_taken), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
- Parametrised fetch-PC generator for the IF stage; successor to the plain stall-able PC register.
- Holds the fetch PC with a configurable reset vector and a BOOT/RUN state machine.
- Takes a redirect from EX/trap logic and predicts taken branches with a direct-mapped branch target buffer (BTB), updated from EX.
- Feeds the instruction-memory address and the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC/target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value held in reset and in BOOT; bits [1:0] must be 0.
- BTB_DEPTH, 16, BTB entries; power of two, >= 2. IDX_W = log2(BTB_DEPTH), TAG_W = XLEN-IDX_W-2.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold PC (load-use / I-mem wait)
- i_redirect_valid  in  1  mispredict/jump/trap redirect
- i_redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- i_upd_valid  in  1  BTB update strobe from EX (resolved control-flow instruction)
- i_upd_pc  in  XLEN  PC of resolved instruction
- i_upd_target  in  XLEN  resolved target
- i_upd_taken  in  1  resolved direction
- o_pc_if  out  XLEN  current fetch PC
- o_pc_valid  out  1  fetch PC is valid this cycle
- o_pred_taken  out  1  BTB predicts taken for o_pc_if
- o_pred_target  out  XLEN  predicted target; 0 when o_pred_taken=0

Behaviour:
- Reset (async, active-low): o_pc_if=RESET_VECTOR, state=BOOT, o_pc_valid=0, all BTB valid bits cleared, o_pred_taken=0, o_pred_target=0.
- BOOT: o_pc_valid=0; first rising edge after reset release goes to RUN; PC does not advance (first fetched PC is RESET_VECTOR). A redirect in BOOT is ignored.
- RUN: o_pc_valid=1. Next-PC priority at each edge:
  - i_redirect_valid -> i_redirect_pc. Overrides stall.
  - else i_stall -> hold.
  - else hit -> entry target.
  - else o_pc_if+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- Lookup: combinational on o_pc_if.
  - idx = o_pc_if[IDX_W+1:2]; tag = o_pc_if[XLEN-1:IDX_W+2].
  - hit = valid[idx] && tag matches.
  - o_pred_taken = hit; o_pred_target = hit ? target[idx] : 0.
- Update: registered, at the edge where i_upd_valid=1; applied regardless of stall or redirect.
  - taken: write valid=1, tag, target at the index of i_upd_pc (replaces any occupant).
  - not taken and tag matches: clear valid.
  - not taken and tag mismatch: no change.
- Same-index update and lookup in one cycle: lookup sees pre-update contents; the new entry is visible from the next cycle.
- Reset asserted mid-operation: immediate return to reset values; pending updates are lost.
- Target bits [1:0] stored as 0.

Optional Feature:
- Macro IF_PC_BHT_EN.
- Defined: each entry gains a 2-bit saturating counter, reset to 2'b01.
  - Taken update on tag hit: counter increments (saturates at 3) and the target is rewritten.
  - Taken update on miss: allocates the entry with counter=2'b10.
  - Not-taken update on hit: counter decrements (saturates at 0); the entry stays valid.
  - hit additionally requires counter[1]=1.
- Not defined: no counters; behaviour exactly as described above.

Decomposition:
- Package if_pkg holds:
  - the typedef for the BOOT/RUN state enum;
  - the btb_entry_t struct (valid, tag, target, optional ctr);
  - the constant INSTR_BYTES=4;
  - the helper functions for idx/tag extraction.
- One sub-module, if_btb: storage, lookup and update (plus counters under the macro).
- if_pc_gen itself contains the PC register, the state machine and the next-PC priority mux.

Test Plan:
- Reset, RESET_VECTOR=0x100, release; no stall/redirect -> o_pc_valid=0 with PC 0x100 for one cycle, then PC sequence 0x100, 0x104, 0x108 with o_pc_valid=1.
- i_stall=1 for 3 cycles at PC 0x20 while i_redirect_valid pulses on the 2nd cycle with 0x80 -> PC 0x20, 0x20, 0x80, then 0x84 after stall drops.
- Update pc=0x40, target=0x200, taken; then fetch reaches 0x40 -> o_pred_taken=1, o_pred_target=0x200, next PC 0x200. Not-taken update for 0x40 -> later fetch of 0x40 goes to 0x44 (without macro).
- Aliasing, BTB_DEPTH=16: entry for 0x40, then taken update for 0x440 (same idx) -> fetch at 0x40 misses (next PC 0x44) and 0x440 hits.
- PC reaches 0xFFFF_FFFC with no hit -> next PC 0x0000_0000. Reset asserted mid-run -> o_pc_if=RESET_VECTOR immediately and all BTB entries miss.
- With IF_PC_BHT_EN: first taken update for 0x40 -> predicted taken. One not-taken update -> counter=01, predicts not taken. Two taken updates -> counter=11, predicts taken.
